rsa_modexp_core: RTL and testbench
==================================

# rsa_modexp_core

Parametrised modular-exponentiation engine computing cal_val = message_val^private_key mod public_key. It is the next-generation RSA encrypt/decrypt datapath: generic width, bit-serial interleaved modular multiplication instead of full exponentiation followed by reduction, a busy/done handshake, error flagging, and a selectable constant-time mode. It sits behind the same start/cal_done control interface as the existing encryptor, so the same key/message sequencing drives it.

## Interface
- WIDTH, 64: operand width in bits for key, modulus, message and result; minimum 4.
- CONST_TIME, 0: 1 = always process all WIDTH exponent bits (data-independent latency); 0 = stop after the highest set exponent bit.
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- private_key  in  WIDTH  exponent.
- public_key  in  WIDTH  modulus n.
- message_val  in  WIDTH  base; any value, including values >= n.
- busy  out  1  high from the edge that accepts start until the edge that asserts cal_done.
- cal_done  out  1  one-cycle pulse: result (or error) valid.
- cal_val  out  WIDTH  result; held from cal_done until the next accepted start.
- err  out  1  set with cal_done when n < 2; held with cal_val.

## Operation
- Reset: state IDLE; busy=0, cal_done=0, cal_val=0, err=0; all working registers 0. Reset mid-operation aborts immediately, no cal_done.
- IDLE: start=1 captures private_key, public_key, message_val into internal registers; later input changes are ignored. If n < 2 go to FINISH with err=1, cal_val=0. Otherwise clear err, go to LOAD.
- LOAD (WIDTH cycles): base = message_val mod n, computed as mulmod(1, message_val); result register = 1.
- mulmod(a, b) with a < n: r=0; for each bit of b, MSB first, one bit per cycle: r = 2r, subtract n if r >= n; if bit set r = r + a, subtract n if r >= n. Intermediates are WIDTH+1 bits wide; r < n is invariant.
- MUL (WIDTH cycles): two mulmod units run in parallel: P = result*base mod n and S = base*base mod n.
- UPD (1 cycle): if current exponent LSB is 1 then result = P; base = S; shift exponent right; increment processed-bit count.
- After LOAD or UPD, go to MUL if more bits remain, otherwise FINISH. CONST_TIME=1: exactly WIDTH bits are processed. CONST_TIME=0: processing stops when the remaining exponent is 0, so exponent 0 goes directly LOAD -> FINISH.
- FINISH (1 cycle): register cal_val = result (or 0 on error), pulse cal_done, drop busy, return to IDLE.
- start while busy=1 is ignored, with no queueing. start in the FINISH cycle is also ignored. start in the cycle after cal_done is accepted.
- Exponent 0 with n >= 2 gives cal_val=1.

## Timing
- Edge E0 accepts start. cal_done is high after edge E0+L, and busy is high after edges E0 .. E0+L-1.
- L = 1 + WIDTH + K*(WIDTH+1).
- K = WIDTH if CONST_TIME=1. Otherwise K = index of the highest set exponent bit + 1, and K = 0 for exponent 0.
- Error path: L = 1.
- Example, WIDTH=8, exponent 3: L=27 with CONST_TIME=0, L=81 with CONST_TIME=1.
- cal_done is exactly one cycle wide. cal_val and err are stable from that edge until the next accepted start.

## Test plan
- WIDTH=8, CONST_TIME=0; n=33, e=3, m=9 -> cal_val=3, err=0, cal_done exactly 27 cycles after start accepted. Then n=33, e=7, m=3 -> cal_val=9, L=1+8+3*9=36.
- Same encryption with CONST_TIME=1 -> cal_val=3, L=81. Repeat with e=7 -> L=81, identical latency.
- Base reduction and exponent 0: n=33, e=1, m=42 -> cal_val=9. n=33, e=0, m=5 -> cal_val=1, L=9.
- Error: n=1 -> err=1, cal_val=0, cal_done one cycle after start. Next, n=0 -> err=1. Then a valid request clears err.
- Handshake: pulse start again mid-operation with different inputs -> ignored, original result 3 returned. Change inputs while busy -> result unaffected. Start held high continuously -> back-to-back runs, each accepted the cycle after cal_done.
- Reset mid-MUL: rst=1 for one cycle -> busy=0, cal_val=0, no cal_done. A new start then completes normally. Also randomised WIDTH=16 vectors checked against a reference model.

Source files
------------

// File: rtl/rsa_modexp_core.sv
// Modular exponentiation engine: cal_val = message_val^private_key mod public_key,
// using bit-serial interleaved modular multiplication and right-to-left square-and-multiply.
module rsa_modexp_core #(
   parameter int unsigned WIDTH      = 64,
   parameter bit          CONST_TIME = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] private_key,
   input  logic [WIDTH-1:0] public_key,
   input  logic [WIDTH-1:0] message_val,
   output logic             busy,
   output logic             cal_done,
   output logic [WIDTH-1:0] cal_val,
   output logic             err
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned KW = $clog2(WIDTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MUL,
      S_UPD,
      S_FINISH
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH-1:0] msg_q, msg_d;
   logic [WIDTH-1:0] base_q, base_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] p_q, p_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [KW-1:0]    nbits_q, nbits_d;
   logic             fail_q, fail_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] val_q, val_d;
   logic             err_q, err_d;

   // One interleaved step: r = 2r mod n, then r = r + a mod n when the multiplier bit is set.
   function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] r,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] n,
                                                input logic             b);
      logic [WIDTH:0] t;
      t = {r, 1'b0};
      if (t >= {1'b0, n}) t = t - {1'b0, n};
      if (b) t = t + {1'b0, a};
      if (t >= {1'b0, n}) t = t - {1'b0, n};
      return t[WIDTH-1:0];
   endfunction

   function automatic logic more_bits(input logic [WIDTH-1:0] e, input logic [KW-1:0] k);
      if (CONST_TIME) return (k < KW'(WIDTH));
      return (e != '0);
   endfunction

   logic [WIDTH-1:0] a_p_c;
   logic [WIDTH-1:0] b_src_c;
   logic             b_bit_c;
   logic [WIDTH-1:0] p_step_c;
   logic [WIDTH-1:0] s_step_c;
   logic [WIDTH-1:0] exp_sh_c;
   logic [KW-1:0]    nbits_inc_c;

   always_comb begin
      state_d  = state_q;
      exp_d    = exp_q;
      n_d      = n_q;
      msg_d    = msg_q;
      base_d   = base_q;
      res_d    = res_q;
      p_d      = p_q;
      s_d      = s_q;
      cnt_d    = cnt_q;
      nbits_d  = nbits_q;
      fail_d   = fail_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      val_d    = val_q;
      err_d    = err_q;

      // LOAD reduces the message as mulmod(1, msg); MUL shares the base bits for P and S.
      a_p_c       = (state_q == S_LOAD) ? WIDTH'(1) : res_q;
      b_src_c     = (state_q == S_LOAD) ? msg_q : base_q;
      b_bit_c     = b_src_c[cnt_q];
      p_step_c    = mm_step(p_q, a_p_c, n_q, b_bit_c);
      s_step_c    = mm_step(s_q, base_q, n_q, b_bit_c);
      exp_sh_c    = exp_q >> 1;
      nbits_inc_c = nbits_q + KW'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               exp_d  = private_key;
               n_d    = public_key;
               msg_d  = message_val;
               p_d    = '0;
               s_d    = '0;
               res_d  = WIDTH'(1);
               cnt_d  = CW'(WIDTH - 1);
               nbits_d = '0;
               if (public_key < WIDTH'(2)) begin
                  fail_d  = 1'b1;
                  state_d = S_FINISH;
               end else begin
                  fail_d  = 1'b0;
                  err_d   = 1'b0;
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            p_d = p_step_c;
            if (cnt_q == '0) begin
               base_d  = p_step_c;
               p_d     = '0;
               s_d     = '0;
               cnt_d   = CW'(WIDTH - 1);
               state_d = more_bits(exp_q, nbits_q) ? S_MUL : S_FINISH;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_MUL: begin
            p_d = p_step_c;
            s_d = s_step_c;
            if (cnt_q == '0) state_d = S_UPD;
            else cnt_d = cnt_q - CW'(1);
         end
         S_UPD: begin
            if (exp_q[0]) res_d = p_q;
            base_d  = s_q;
            exp_d   = exp_sh_c;
            nbits_d = nbits_inc_c;
            p_d     = '0;
            s_d     = '0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = more_bits(exp_sh_c, nbits_inc_c) ? S_MUL : S_FINISH;
         end
         S_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            err_d   = fail_q;
            val_d   = fail_q ? '0 : res_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         exp_q   <= '0;
         n_q     <= '0;
         msg_q   <= '0;
         base_q  <= '0;
         res_q   <= '0;
         p_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         nbits_q <= '0;
         fail_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         val_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         n_q     <= n_d;
         msg_q   <= msg_d;
         base_q  <= base_d;
         res_q   <= res_d;
         p_q     <= p_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         nbits_q <= nbits_d;
         fail_q  <= fail_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         val_q   <= val_d;
         err_q   <= err_d;
      end
   end

   assign busy     = busy_q;
   assign cal_done = done_q;
   assign cal_val  = val_q;
   assign err      = err_q;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Bench for rsa_modexp_core: directed and random requests on three configurations
// (8-bit variable-time, 8-bit constant-time, 16-bit variable-time) against an arithmetic model.
module tb_rsa_modexp_core;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [15:0] key_v [3];
   logic [15:0] mod_v [3];
   logic [15:0] msg_v [3];
   logic [2:0]  start_v;
   logic [2:0]  busy_w;
   logic [2:0]  done_w;
   logic [2:0]  err_w;
   logic [7:0]  val0, val1;
   logic [15:0] val2;

   int total = 0;
   int bad   = 0;

   rsa_modexp_core #(.WIDTH(8), .CONST_TIME(1'b0)) u_v8 (
      .clk(clk), .rst(rst), .start(start_v[0]),
      .private_key(key_v[0][7:0]), .public_key(mod_v[0][7:0]), .message_val(msg_v[0][7:0]),
      .busy(busy_w[0]), .cal_done(done_w[0]), .cal_val(val0), .err(err_w[0]));

   rsa_modexp_core #(.WIDTH(8), .CONST_TIME(1'b1)) u_c8 (
      .clk(clk), .rst(rst), .start(start_v[1]),
      .private_key(key_v[1][7:0]), .public_key(mod_v[1][7:0]), .message_val(msg_v[1][7:0]),
      .busy(busy_w[1]), .cal_done(done_w[1]), .cal_val(val1), .err(err_w[1]));

   rsa_modexp_core #(.WIDTH(16), .CONST_TIME(1'b0)) u_v16 (
      .clk(clk), .rst(rst), .start(start_v[2]),
      .private_key(key_v[2]), .public_key(mod_v[2]), .message_val(msg_v[2]),
      .busy(busy_w[2]), .cal_done(done_w[2]), .cal_val(val2), .err(err_w[2]));

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint val_of(input int sel);
      case (sel)
         0: return longint'(val0);
         1: return longint'(val1);
         default: return longint'(val2);
      endcase
   endfunction

   // Reference: plain square-and-multiply on integers.
   function automatic longint model_pow(input longint e, input longint n, input longint m);
      longint r, b, x;
      if (n < 2) return 0;
      r = 1;
      b = m % n;
      x = e;
      while (x != 0) begin
         if (x % 2 == 1) r = (r * b) % n;
         b = (b * b) % n;
         x = x / 2;
      end
      return r;
   endfunction

   function automatic int model_lat(input int w, input bit ct, input longint e, input longint n);
      int k;
      if (n < 2) return 1;
      k = 0;
      if (ct) k = w;
      else for (int i = 0; i < w; i++) if (((e >> i) & 1) == 1) k = i + 1;
      return 1 + w + k * (w + 1);
   endfunction

   // One request; want < 0 means take the expected result from the model only.
   task automatic run_op(input int sel, input logic [15:0] e, input logic [15:0] n,
                         input logic [15:0] m, input bit disturb, input longint want,
                         input string tag);
      int     w, lat, el;
      bit     ct;
      longint me, mn, mm, ev;
      w  = (sel == 2) ? 16 : 8;
      ct = (sel == 1);
      me = (w == 8) ? longint'(e[7:0]) : longint'(e);
      mn = (w == 8) ? longint'(n[7:0]) : longint'(n);
      mm = (w == 8) ? longint'(m[7:0]) : longint'(m);
      ev = model_pow(me, mn, mm);
      el = model_lat(w, ct, me, mn);
      if (want >= 0) check({tag, "/model"}, ev, want);
      @(negedge clk);
      key_v[sel] = e; mod_v[sel] = n; msg_v[sel] = m; start_v[sel] = 1'b1;
      @(posedge clk); #1;
      start_v[sel] = 1'b0;
      check({tag, "/busy_on"}, longint'(busy_w[sel]), 1);
      lat = 0;
      while (!done_w[sel] && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
         if (disturb && lat == 4) begin
            start_v[sel] = 1'b1;
            key_v[sel] = 16'($urandom); mod_v[sel] = 16'($urandom); msg_v[sel] = 16'($urandom);
         end
         if (disturb && lat == 5) start_v[sel] = 1'b0;
      end
      check({tag, "/latency"}, lat, el);
      check({tag, "/val"}, val_of(sel), ev);
      check({tag, "/err"}, longint'(err_w[sel]), (mn < 2) ? 1 : 0);
      check({tag, "/busy_off"}, longint'(busy_w[sel]), 0);
      @(posedge clk); #1;
      check({tag, "/pulse"}, longint'(done_w[sel]), 0);
      check({tag, "/hold"}, val_of(sel), ev);
   endtask

   initial begin
      int lat;
      bit seen;
      logic [15:0] re, rn, rm;
      for (int i = 0; i < 3; i++) begin
         key_v[i] = '0; mod_v[i] = '0; msg_v[i] = '0;
      end
      start_v = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset/busy", longint'(busy_w), 0);
      check("reset/done", longint'(done_w), 0);
      check("reset/err", longint'(err_w), 0);
      check("reset/val", val_of(0) + val_of(1) + val_of(2), 0);

      run_op(0, 16'd3, 16'd33, 16'd9,  1'b0, 3, "v8_e3");
      run_op(0, 16'd7, 16'd33, 16'd3,  1'b0, 9, "v8_e7");
      run_op(1, 16'd3, 16'd33, 16'd9,  1'b0, 3, "c8_e3");
      run_op(1, 16'd7, 16'd33, 16'd3,  1'b0, 9, "c8_e7");
      run_op(0, 16'd1, 16'd33, 16'd42, 1'b0, 9, "v8_reduce");
      run_op(0, 16'd0, 16'd33, 16'd5,  1'b0, 1, "v8_exp0");
      run_op(0, 16'd5, 16'd1,  16'd7,  1'b0, 0, "err_n1");
      run_op(0, 16'd5, 16'd0,  16'd7,  1'b0, 0, "err_n0");
      run_op(0, 16'd3, 16'd33, 16'd9,  1'b0, 3, "err_clear");
      run_op(0, 16'd3, 16'd33, 16'd9,  1'b1, 3, "disturb");

      // Start held high: each run is accepted on the edge right after cal_done.
      @(negedge clk);
      key_v[0] = 16'd3; mod_v[0] = 16'd33; msg_v[0] = 16'd9; start_v[0] = 1'b1;
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
         lat = 0;
         while (!done_w[0] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
         end
         check("b2b/latency", lat, 27);
         check("b2b/val", val_of(0), 3);
         if (r == 1) start_v[0] = 1'b0;
         @(posedge clk); #1;
         check("b2b/pulse", longint'(done_w[0]), 0);
         check("b2b/busy", longint'(busy_w[0]), (r == 0) ? 1 : 0);
      end

      // Reset in the middle of a MUL phase aborts without cal_done.
      @(negedge clk);
      key_v[0] = 16'd7; mod_v[0] = 16'd33; msg_v[0] = 16'd3; start_v[0] = 1'b1;
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      repeat (14) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_mid/busy", longint'(busy_w[0]), 0);
      check("rst_mid/val", val_of(0), 0);
      check("rst_mid/done", longint'(done_w[0]), 0);
      seen = 1'b0;
      repeat (60) begin
         @(posedge clk); #1;
         if (done_w[0]) seen = 1'b1;
      end
      check("rst_mid/no_done", longint'(seen), 0);
      run_op(0, 16'd7, 16'd33, 16'd3, 1'b0, 9, "after_rst");

      for (int i = 0; i < 16; i++) begin
         rn = 16'($urandom);
         if (i % 7 == 3) rn = 16'($urandom_range(0, 1));
         re = (i % 4 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
         rm = 16'($urandom);
         run_op(2, re, rn, rm, 1'b0, -1, "rand16");
      end
      for (int i = 0; i < 4; i++) begin
         rn = 16'($urandom_range(2, 255));
         run_op(1, 16'($urandom_range(0, 255)), rn, 16'($urandom_range(0, 255)), 1'b0, -1, "rand8c");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
